// File: rtl/bank_wr_sched.sv
// Write sequencer for the banked state-vector memory: broadcast fill or
// bank-interleaved stream write-back, driving the bank write-enable decoder.
module bank_wr_sched #(
    parameter int unsigned N      = 1,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] bcast_data,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [N-1:0]      sel,
    output logic              all,
    output logic              w_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, BCAST, STREAM, DONE} state_t;

    localparam logic [N-1:0]      BCNT_MAX = '1;
    localparam logic [ADDR_W-1:0] ACNT_MAX = '1;

    state_t              state, state_nxt;
    logic [N-1:0]        bcnt, bcnt_nxt;
    logic [ADDR_W-1:0]   acnt, acnt_nxt;
    logic [DATA_W-1:0]   word, word_nxt;
    logic [N-1:0]        sel_nxt;
    logic                all_nxt, w_en_nxt, done_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;

    assign in_ready = (state == STREAM) & ~abort;
    assign busy     = (state == BCAST) | (state == STREAM);

    // State, counters and all write outputs registered together
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bcnt  <= '0;
            acnt  <= '0;
            word  <= '0;
            sel   <= '0;
            all   <= 1'b0;
            w_en  <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
            acnt  <= acnt_nxt;
            word  <= word_nxt;
            sel   <= sel_nxt;
            all   <= all_nxt;
            w_en  <= w_en_nxt;
            addr  <= addr_nxt;
            wdata <= wdata_nxt;
            done  <= done_nxt;
        end
    end

    // Next state and next write; outputs other than strobes hold between writes
    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        acnt_nxt  = acnt;
        word_nxt  = word;
        sel_nxt   = sel;
        all_nxt   = all;
        addr_nxt  = addr;
        wdata_nxt = wdata;
        w_en_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    word_nxt  = bcast_data;
                    bcnt_nxt  = '0;
                    acnt_nxt  = '0;
                    state_nxt = mode ? BCAST : STREAM;
                end
            end
            BCAST: begin
                if (abort) begin
                    state_nxt = IDLE;
                    bcnt_nxt  = '0;
                    acnt_nxt  = '0;
                end else begin
                    w_en_nxt  = 1'b1;
                    all_nxt   = 1'b1;
                    sel_nxt   = '0;
                    addr_nxt  = acnt;
                    wdata_nxt = word;
                    acnt_nxt  = acnt + ADDR_W'(1);
                    if (acnt == ACNT_MAX) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (abort) begin
                    state_nxt = IDLE;
                    bcnt_nxt  = '0;
                    acnt_nxt  = '0;
                end else if (in_valid) begin
                    w_en_nxt  = 1'b1;
                    all_nxt   = 1'b0;
                    sel_nxt   = bcnt;
                    addr_nxt  = acnt;
                    wdata_nxt = in_data;
                    bcnt_nxt  = bcnt + N'(1);
                    // Banks interleave inside an address; address advances on bank wrap
                    if (bcnt == BCNT_MAX) begin
                        acnt_nxt = acnt + ADDR_W'(1);
                        if (acnt == ACNT_MAX) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bank_wr_sched.sv
// Bench for bank_wr_sched: per-cycle compare against a write-index model,
// plus literal expectations on the logged write sequences.
module tb_bank_wr_sched;

    localparam int NB    = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, mode = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [31:0] bcast_data = '0, in_data = '0;
    logic        in_ready, sel, all, w_en, busy, done;
    logic [1:0]  addr;
    logic [31:0] wdata;

    logic        start2 = 1'b0, in_valid2 = 1'b0;
    logic [31:0] in_data2 = '0;
    logic        in_ready2, all2, w_en2, busy2, done2;
    logic [1:0]  sel2, addr2;
    logic [31:0] wdata2;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bank_wr_sched #(.N(1), .ADDR_W(2), .DATA_W(32)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bcast_data(bcast_data),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sel(sel), .all(all), .w_en(w_en), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done)
    );

    bank_wr_sched #(.N(2), .ADDR_W(2), .DATA_W(32)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(1'b0), .bcast_data(32'h0),
        .abort(1'b0), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .sel(sel2), .all(all2), .w_en(w_en2), .addr(addr2), .wdata(wdata2),
        .busy(busy2), .done(done2)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: a job is a linear count of writes k; the write's bank/address follow from k
    int          m_phase = 0;   // 0 idle, 1 fill, 2 stream, 3 done
    int          m_k = 0;
    logic [31:0] m_word = '0;
    logic        e_sel = 0, e_all = 0, e_wen = 0, e_done = 0;
    logic [1:0]  e_addr = '0;
    logic [31:0] e_wdata = '0;

    always @(posedge clk) begin : model
        int ph, k;
        ph = m_phase;
        k  = m_k;
        if (rst) begin
            m_phase <= 0; m_k <= 0; m_word <= '0;
            e_sel <= 0; e_all <= 0; e_wen <= 0; e_done <= 0; e_addr <= '0; e_wdata <= '0;
        end else begin
            e_wen  <= 1'b0;
            e_done <= 1'b0;
            case (ph)
                0: if (start) begin
                    m_word <= bcast_data;
                    k  = 0;
                    ph = mode ? 1 : 2;
                end
                1: if (abort) begin
                    ph = 0; k = 0;
                end else begin
                    e_wen <= 1'b1; e_all <= 1'b1; e_sel <= 1'b0;
                    e_addr <= 2'(k); e_wdata <= m_word;
                    k++;
                    if (k == DEPTH) begin ph = 3; e_done <= 1'b1; end
                end
                2: if (abort) begin
                    ph = 0; k = 0;
                end else if (in_valid) begin
                    e_wen <= 1'b1; e_all <= 1'b0; e_sel <= 1'(k % NB);
                    e_addr <= 2'(k / NB); e_wdata <= in_data;
                    k++;
                    if (k == NB * DEPTH) begin ph = 3; e_done <= 1'b1; end
                end
                default: ph = 0;
            endcase
            m_phase <= ph;
            m_k     <= k;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sel", 64'(sel), 64'(e_sel));
            check("all", 64'(all), 64'(e_all));
            check("w_en", 64'(w_en), 64'(e_wen));
            check("addr", 64'(addr), 64'(e_addr));
            check("wdata", 64'(wdata), 64'(e_wdata));
            check("done", 64'(done), 64'(e_done));
            check("busy", 64'(busy), 64'(m_phase == 1 || m_phase == 2));
            check("in_ready", 64'(in_ready), 64'(m_phase == 2 && !abort));
        end
    end

    typedef struct {
        int          sel;
        int          addr;
        logic [31:0] data;
        bit          all;
        bit          done;
    } wr_t;

    wr_t log_q[$];
    wr_t log2_q[$];
    int  done_cnt = 0;
    int  done2_cnt = 0;

    always @(negedge clk) begin
        wr_t w;
        if (w_en === 1'b1) begin
            w.sel = int'(sel); w.addr = int'(addr); w.data = wdata; w.all = all; w.done = done;
            log_q.push_back(w);
        end
        if (done === 1'b1) done_cnt++;
        if (w_en2 === 1'b1) begin
            w.sel = int'(sel2); w.addr = int'(addr2); w.data = wdata2; w.all = all2; w.done = done2;
            log2_q.push_back(w);
        end
        if (done2 === 1'b1) done2_cnt++;
    end

    int exp_sel[8]  = '{0, 1, 0, 1, 0, 1, 0, 1};
    int exp_addr[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    task automatic clear_logs();
        log_q.delete();
        done_cnt = 0;
    endtask

    task automatic check_stream_log(input string tag, input logic [31:0] base);
        check({tag, "_nwr"}, 64'(log_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            check({tag, "_sel"}, 64'(log_q[i].sel), 64'(exp_sel[i]));
            check({tag, "_addr"}, 64'(log_q[i].addr), 64'(exp_addr[i]));
            check({tag, "_data"}, 64'(log_q[i].data), 64'(base + 32'(i)));
            check({tag, "_all"}, 64'(log_q[i].all), 64'd0);
        end
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic launch(input logic m, input logic [31:0] word);
        mode = m; bcast_data = word; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        check("rst_w_en", 64'(w_en), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        step();

        // 1: fill with zero word
        clear_logs();
        launch(1'b1, 32'h0);
        repeat (7) step();
        check("t1_nwr", 64'(log_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check("t1_addr", 64'(log_q[i].addr), 64'(i));
            check("t1_all", 64'(log_q[i].all), 64'd1);
            check("t1_done_with_wr", 64'(log_q[i].done), 64'(i == 3));
        end
        check("t1_done_cnt", 64'(done_cnt), 64'd1);

        // 2: back-to-back stream
        clear_logs();
        launch(1'b0, 32'h0);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'h10 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        check_stream_log("t2", 32'h10);

        // 3: stream with two-cycle gaps before beats 3 and 6
        clear_logs();
        launch(1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3 || i == 6) begin
                in_valid = 1'b0;
                repeat (2) step();
            end
            in_valid = 1'b1;
            in_data = 32'h10 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        check_stream_log("t3", 32'h10);

        // 4: start pulses during fill and during DONE are ignored
        clear_logs();
        launch(1'b1, 32'hA5A5_0001);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("t4_done_cycle", 64'(done), 64'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check("t4_nwr", 64'(log_q.size()), 64'd4);
        check("t4_done_cnt", 64'(done_cnt), 64'd1);
        check("t4_busy_end", 64'(busy), 64'd0);
        if (log_q.size() > 0) check("t4_data", 64'(log_q[0].data), 64'h0000_0000_A5A5_0001);

        // 5: abort after three beats, then a fresh stream
        clear_logs();
        launch(1'b0, 32'h0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h20 + 32'(i);
            step();
        end
        abort = 1'b1;
        in_data = 32'hDEAD_BEEF;
        #1;
        check("t5_ready_abort", 64'(in_ready), 64'd0);
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        check("t5_idle_busy", 64'(busy), 64'd0);
        check("t5_idle_w_en", 64'(w_en), 64'd0);
        repeat (2) step();
        check("t5_nwr", 64'(log_q.size()), 64'd3);
        check("t5_no_done", 64'(done_cnt), 64'd0);
        clear_logs();
        launch(1'b0, 32'h0);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'h30 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        check_stream_log("t5b", 32'h30);

        // 6: reset in the middle of a fill
        clear_logs();
        launch(1'b1, 32'hFFFF_0000);
        repeat (3) step();
        check("t6_pre_addr", 64'(addr), 64'd2);
        rst = 1'b1;
        step();
        check("t6_sel", 64'(sel), 64'd0);
        check("t6_all", 64'(all), 64'd0);
        check("t6_w_en", 64'(w_en), 64'd0);
        check("t6_addr", 64'(addr), 64'd0);
        check("t6_wdata", 64'(wdata), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        repeat (2) step();

        // 6b: four banks, full stream
        log2_q.delete();
        done2_cnt = 0;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        in_valid2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data2 = 32'h40 + 32'(i);
            step();
        end
        in_valid2 = 1'b0;
        repeat (3) step();
        check("t6b_nwr", 64'(log2_q.size()), 64'd16);
        for (int i = 0; i < 16 && i < log2_q.size(); i++) begin
            check("t6b_sel", 64'(log2_q[i].sel), 64'(i % 4));
            check("t6b_addr", 64'(log2_q[i].addr), 64'(i / 4));
            check("t6b_data", 64'(log2_q[i].data), 64'(32'h40 + 32'(i)));
        end
        if (log2_q.size() > 5) begin
            check("t6b_lit_sel5", 64'(log2_q[5].sel), 64'd1);
            check("t6b_lit_addr5", 64'(log2_q[5].addr), 64'd1);
        end
        check("t6b_done_cnt", 64'(done2_cnt), 64'd1);
        check("t6b_busy_end", 64'(busy2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
